// File: rtl/ct_lsu_pfu_gsdb_if.sv
// Load-stream and gpfb-side signals of the global stride detection buffer.
// create_vld / pop_req are single-cycle pulses with no back-pressure: gpfb must act on them the cycle they are high.
interface ct_lsu_pfu_gsdb_if;
  logic        ld_da_pfu_act_vld;
  logic        ld_da_pfu_pf_inst_vld;
  logic [39:0] ld_da_pfu_va;
  logic        pfu_gpfb_vld;
  logic        pfu_gsdb_gpfb_create_vld;
  logic        pfu_gsdb_gpfb_pop_req;
  logic [10:0] pfu_gsdb_stride;
  logic        pfu_gsdb_stride_neg;
  logic [6:0]  pfu_gsdb_strideh_6to0;
  logic        pfu_gsdb_vld;

  modport slave (
    input  ld_da_pfu_act_vld, ld_da_pfu_pf_inst_vld, ld_da_pfu_va, pfu_gpfb_vld,
    output pfu_gsdb_gpfb_create_vld, pfu_gsdb_gpfb_pop_req, pfu_gsdb_stride,
           pfu_gsdb_stride_neg, pfu_gsdb_strideh_6to0, pfu_gsdb_vld
  );

  modport master (
    output ld_da_pfu_act_vld, ld_da_pfu_pf_inst_vld, ld_da_pfu_va, pfu_gpfb_vld,
    input  pfu_gsdb_gpfb_create_vld, pfu_gsdb_gpfb_pop_req, pfu_gsdb_stride,
           pfu_gsdb_stride_neg, pfu_gsdb_strideh_6to0, pfu_gsdb_vld
  );
endinterface

// File: rtl/ct_lsu_pfu_gsdb.sv
// Global stride detection buffer: trains one global stride from the DA-stage load
// stream and tells the global prefetch buffer when to create or drop its stream.
module ct_lsu_pfu_gsdb #(
  parameter int CONF_THRESH = 3,
  parameter int CNT_W       = 3
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst_b,
  input  logic             pfu_dcache_pref_en,
  input  logic             pfu_l2_pref_en,
  input  logic [1:0]       cp0_yy_priv_mode,
  input  logic             pfu_pop_all_vld,
  ct_lsu_pfu_gsdb_if.slave gsdb,
  output logic [1:0]       dbg_state,
  output logic [CNT_W-1:0] dbg_cnt
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TRAIN     = 2'd1,
    CONFIRMED = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] THRESH     = CNT_W'(CONF_THRESH);
  localparam logic [CNT_W-1:0] THRESH_M1  = CNT_W'(CONF_THRESH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e           state, state_nxt;
  logic [39:0]      prev_va, prev_va_nxt;
  logic [10:0]      stride_reg, stride_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       priv_ff;
  logic             en_ff;
  logic             create_q, create_nxt;
  logic             pop_q, pop_nxt;

  logic             en;
  logic             sample;
  logic [39:0]      diff;
  logic             in_range;
  logic             diff_zero;
  logic             stride_match;
  logic             ctx_change;
  logic             gpfb_lost;
  logic [CNT_W-1:0] cnt_inc;
  logic [10:0]      stride_abs;

  assign en           = pfu_dcache_pref_en | pfu_l2_pref_en;
  assign sample       = gsdb.ld_da_pfu_act_vld & gsdb.ld_da_pfu_pf_inst_vld & en;
  assign diff         = gsdb.ld_da_pfu_va - prev_va;
  assign in_range     = (diff[39:10] == '0) | (diff[39:10] == '1);
  assign diff_zero    = (diff == '0);
  assign stride_match = (diff[10:0] == stride_reg);
  assign ctx_change   = (cp0_yy_priv_mode != priv_ff) | (en_ff & ~en);
  assign cnt_inc      = cnt + CNT_ONE;
  // gpfb only raises its valid the cycle after our create pulse, so that cycle is exempt.
  assign gpfb_lost    = (state == CONFIRMED) & ~create_q & ~gsdb.pfu_gpfb_vld;

  always_comb begin
    state_nxt   = state;
    prev_va_nxt = prev_va;
    stride_nxt  = stride_reg;
    cnt_nxt     = cnt;
    create_nxt  = 1'b0;
    pop_nxt     = 1'b0;
    if (pfu_pop_all_vld) begin
      state_nxt   = IDLE;
      prev_va_nxt = '0;
      stride_nxt  = '0;
      cnt_nxt     = '0;
    end else if (ctx_change) begin
      state_nxt   = IDLE;
      prev_va_nxt = '0;
      stride_nxt  = '0;
      cnt_nxt     = '0;
      pop_nxt     = (state == CONFIRMED);
    end else if (gpfb_lost) begin
      // One more matching sample re-creates the stream.
      state_nxt = TRAIN;
      cnt_nxt   = THRESH_M1;
    end else if (sample && ((state == IDLE) || !diff_zero)) begin
      prev_va_nxt = gsdb.ld_da_pfu_va;
      unique case (state)
        IDLE: begin
          state_nxt = TRAIN;
          cnt_nxt   = '0;
        end
        TRAIN: begin
          if (!in_range) begin
            cnt_nxt    = '0;
            stride_nxt = '0;
          end else if (stride_match && (cnt != '0)) begin
            if (cnt_inc >= THRESH) begin
              state_nxt  = CONFIRMED;
              cnt_nxt    = THRESH;
              create_nxt = 1'b1;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end else begin
            stride_nxt = diff[10:0];
            cnt_nxt    = CNT_ONE;
          end
        end
        CONFIRMED: begin
          if (!in_range) begin
            state_nxt  = TRAIN;
            stride_nxt = '0;
            cnt_nxt    = '0;
            pop_nxt    = 1'b1;
          end else if (!stride_match) begin
            state_nxt  = TRAIN;
            stride_nxt = diff[10:0];
            cnt_nxt    = CNT_ONE;
            pop_nxt    = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst_b) begin
      state      <= IDLE;
      prev_va    <= '0;
      stride_reg <= '0;
      cnt        <= '0;
      priv_ff    <= '0;
      en_ff      <= 1'b0;
      create_q   <= 1'b0;
      pop_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      prev_va    <= prev_va_nxt;
      stride_reg <= stride_nxt;
      cnt        <= cnt_nxt;
      priv_ff    <= cp0_yy_priv_mode;
      en_ff      <= en;
      create_q   <= create_nxt;
      pop_q      <= pop_nxt;
    end
  end

  assign stride_abs = stride_reg[10] ? (~stride_reg + 11'd1) : stride_reg;

  assign gsdb.pfu_gsdb_gpfb_create_vld = create_q;
  assign gsdb.pfu_gsdb_gpfb_pop_req    = pop_q;
  assign gsdb.pfu_gsdb_stride          = stride_reg;
  assign gsdb.pfu_gsdb_stride_neg      = stride_reg[10];
  assign gsdb.pfu_gsdb_strideh_6to0    = stride_abs[10:4];
  assign gsdb.pfu_gsdb_vld             = (state != IDLE);

  assign dbg_state = state;
  assign dbg_cnt   = cnt;

endmodule

// File: tb/tb_ct_lsu_pfu_gsdb.sv
// Directed bench for ct_lsu_pfu_gsdb: expected create/pop pulses are queued with
// their due cycle and checked by a monitor running alongside the stimulus.
module tb_ct_lsu_pfu_gsdb;
  localparam int W = 36;
  localparam logic [1:0] S_IDLE = 2'd0, S_TRAIN = 2'd1, S_CONF = 2'd2;

  logic       clk = 1'b0;
  logic       rst;
  logic       dc_en, l2_en, pop_all;
  logic [1:0] priv;
  logic [1:0] dbg_state;
  logic [2:0] dbg_cnt;
  logic       gv = 1'b0;
  logic       drop;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [W-1:0] exp_q[$];

  ct_lsu_pfu_gsdb_if bus();

  ct_lsu_pfu_gsdb #(.CONF_THRESH(3), .CNT_W(3)) dut (
    .forever_cpuclk     (clk),
    .cpurst_b           (rst),
    .pfu_dcache_pref_en (dc_en),
    .pfu_l2_pref_en     (l2_en),
    .cp0_yy_priv_mode   (priv),
    .pfu_pop_all_vld    (pop_all),
    .gsdb               (bus.slave),
    .dbg_state          (dbg_state),
    .dbg_cnt            (dbg_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // small gpfb model: holds a stream from create until pop, flush or forced drop
  always @(posedge clk) begin
    if (rst || pop_all || drop) gv <= 1'b0;
    else if (bus.pfu_gsdb_gpfb_create_vld) gv <= 1'b1;
    else if (bus.pfu_gsdb_gpfb_pop_req) gv <= 1'b0;
  end
  assign bus.pfu_gpfb_vld = gv;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [39:0] va);
    bus.ld_da_pfu_act_vld     = 1'b1;
    bus.ld_da_pfu_pf_inst_vld = 1'b1;
    bus.ld_da_pfu_va          = va;
    tick();
    bus.ld_da_pfu_act_vld     = 1'b0;
    bus.ld_da_pfu_pf_inst_vld = 1'b0;
  endtask

  // kind 1 = create, 0 = pop; due in the cycle after the current one
  task automatic expect_pulse(input logic kind, input logic [10:0] s, input logic n, input logic [6:0] h);
    exp_q.push_back({16'(cyc + 1), kind, s, n, h});
  endtask

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [W-1:0] got, e;
    forever begin
      @(negedge clk);
      if (bus.pfu_gsdb_gpfb_create_vld || bus.pfu_gsdb_gpfb_pop_req) begin
        n_cmp++;
        got = {16'(cyc), bus.pfu_gsdb_gpfb_create_vld, bus.pfu_gsdb_stride,
               bus.pfu_gsdb_stride_neg, bus.pfu_gsdb_strideh_6to0};
        if (bus.pfu_gsdb_gpfb_create_vld && bus.pfu_gsdb_gpfb_pop_req) begin
          n_err++;
          $display("FAIL pulse_excl: create and pop both high at cycle %0d", cyc);
        end else if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL pulse_unexp: got %0h expected no pulse", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_err++;
            $display("FAIL pulse: got {cyc,kind,stride,neg,h}=%0h expected %0h", got, e);
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; dc_en = 1'b1; l2_en = 1'b1; pop_all = 1'b0; priv = 2'b00; drop = 1'b0;
    bus.ld_da_pfu_act_vld = 1'b0; bus.ld_da_pfu_pf_inst_vld = 1'b0; bus.ld_da_pfu_va = '0;
    fork monitor(); join_none
    tick(3);
    chk("reset_outs", 40'({bus.pfu_gsdb_gpfb_create_vld, bus.pfu_gsdb_gpfb_pop_req, bus.pfu_gsdb_stride,
                           bus.pfu_gsdb_stride_neg, bus.pfu_gsdb_strideh_6to0, bus.pfu_gsdb_vld}), 40'd0);
    chk("reset_state", 40'(dbg_state), 40'(S_IDLE));
    rst = 1'b0;
    tick();

    // +64 stream confirms on the 4th sample
    send(40'h1000); send(40'h1040); send(40'h1080);
    chk("pos_no_early", 40'(dbg_cnt), 40'd2);
    expect_pulse(1'b1, 11'h040, 1'b0, 7'h04);
    send(40'h10C0);
    chk("pos_confirmed", 40'(dbg_state), 40'(S_CONF));
    chk("pos_vld", 40'(bus.pfu_gsdb_vld), 40'd1);
    tick(2);

    // matching sample is silent, stride change pops and retrains
    send(40'h1100);
    expect_pulse(1'b0, 11'h080, 1'b0, 7'h08);
    send(40'h1180);
    chk("chg_state", 40'(dbg_state), 40'(S_TRAIN));
    chk("chg_cnt", 40'(dbg_cnt), 40'd1);
    send(40'h1200);
    expect_pulse(1'b1, 11'h080, 1'b0, 7'h08);
    send(40'h1280);
    tick(2);

    // flush with a simultaneous sample: no pop, sample dropped
    pop_all = 1'b1;
    send(40'h1300);
    pop_all = 1'b0;
    chk("flush_vld", 40'(bus.pfu_gsdb_vld), 40'd0);
    chk("flush_state", 40'(dbg_state), 40'(S_IDLE));

    // negative stride
    send(40'h2000); send(40'h1F80); send(40'h1F00);
    expect_pulse(1'b1, 11'h780, 1'b1, 7'h08);
    send(40'h1E80);
    tick(2);

    // privilege change while confirmed
    expect_pulse(1'b0, 11'h000, 1'b0, 7'h00);
    priv = 2'b11;
    tick();
    chk("priv_state", 40'(dbg_state), 40'(S_IDLE));
    tick();

    // out-of-range break and repeated address
    send(40'h3000); send(40'h3040);
    send(40'h3040);
    chk("same_va_cnt", 40'(dbg_cnt), 40'd1);
    send(40'h3080);
    send(40'h3880);
    chk("oor_cnt", 40'(dbg_cnt), 40'd0);
    chk("oor_stride", 40'(bus.pfu_gsdb_stride), 40'd0);
    send(40'h38C0); send(40'h3900);
    chk("oor_retrain", 40'(dbg_state), 40'(S_TRAIN));
    expect_pulse(1'b1, 11'h040, 1'b0, 7'h04);
    send(40'h3940);
    tick(2);

    // flush beats a privilege change in the same cycle
    pop_all = 1'b1; priv = 2'b00;
    tick();
    pop_all = 1'b0;
    chk("flush_priv_state", 40'(dbg_state), 40'(S_IDLE));

    // 40-bit wrap, then an out-of-range jump while confirmed
    send(40'hFF_FFFF_FF40); send(40'hFF_FFFF_FF80); send(40'hFF_FFFF_FFC0);
    expect_pulse(1'b1, 11'h040, 1'b0, 7'h04);
    send(40'h00_0000_0000);
    tick(2);
    expect_pulse(1'b0, 11'h000, 1'b0, 7'h00);
    send(40'h5000);
    chk("conf_oor_cnt", 40'(dbg_cnt), 40'd0);
    send(40'h5040); send(40'h5080);
    expect_pulse(1'b1, 11'h040, 1'b0, 7'h04);
    send(40'h50C0);
    tick(2);

    // gpfb drops its stream: back to training one short of threshold
    drop = 1'b1;
    tick();
    drop = 1'b0;
    tick();
    chk("drop_state", 40'(dbg_state), 40'(S_TRAIN));
    chk("drop_cnt", 40'(dbg_cnt), 40'd2);
    chk("drop_stride", 40'(bus.pfu_gsdb_stride), 40'h040);
    expect_pulse(1'b1, 11'h040, 1'b0, 7'h04);
    send(40'h5100);
    tick(2);

    // reset mid-training
    pop_all = 1'b1; tick(); pop_all = 1'b0;
    send(40'h6000); send(40'h6040); send(40'h6080);
    chk("pre_rst_cnt", 40'(dbg_cnt), 40'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_outs", 40'({bus.pfu_gsdb_gpfb_create_vld, bus.pfu_gsdb_gpfb_pop_req, bus.pfu_gsdb_stride,
                         bus.pfu_gsdb_stride_neg, bus.pfu_gsdb_strideh_6to0, bus.pfu_gsdb_vld}), 40'd0);
    chk("rst_cnt", 40'(dbg_cnt), 40'd0);
    send(40'h60C0); send(40'h6100); send(40'h6140);
    chk("rst_three_state", 40'(dbg_state), 40'(S_TRAIN));
    expect_pulse(1'b1, 11'h040, 1'b0, 7'h04);
    send(40'h6180);
    tick(2);

    // prefetch enable falls while confirmed
    expect_pulse(1'b0, 11'h000, 1'b0, 7'h00);
    dc_en = 1'b0; l2_en = 1'b0;
    tick();
    chk("en_drop_state", 40'(dbg_state), 40'(S_IDLE));
    tick(4);

    chk("exp_q_drained", 40'(exp_q.size()), 40'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ct_lsu_pfu_gsdb.md
Name: ct_lsu_pfu_gsdb

Overview:
Global stride detection buffer in the LSU prefetch unit. It sits directly upstream of the global prefetch buffer (gpfb). It watches the committed load stream in the DA stage and trains a single global stride. On confirmation it issues a one-cycle create to gpfb with the stride. When the pattern breaks or context changes it issues a one-cycle pop request.

Parameters:
CONF_THRESH, 3, number of consecutive equal in-range strides needed to confirm a stream (2..7)
CNT_W, 3, width of the confidence counter; must hold CONF_THRESH

Ports:
forever_cpuclk  in  1  block clock; all state on rising edge
cpurst_b  in  1  reset; synchronous, active-high (polarity fixed despite the name)
pfu_dcache_pref_en  in  1  L1 prefetch enable
pfu_l2_pref_en  in  1  L2 prefetch enable
cp0_yy_priv_mode  in  2  current privilege mode
ld_da_pfu_act_vld  in  1  load in DA stage is valid
ld_da_pfu_pf_inst_vld  in  1  load is prefetch-eligible
ld_da_pfu_va  in  40  load virtual address
pfu_pop_all_vld  in  1  global prefetch flush
pfu_gpfb_vld  in  1  gpfb currently holds a stream
pfu_gsdb_gpfb_create_vld  out  1  one-cycle pulse: create gpfb stream
pfu_gsdb_gpfb_pop_req  out  1  one-cycle pulse: gpfb must drop its stream
pfu_gsdb_stride  out  11  trained stride, two's complement, bytes
pfu_gsdb_stride_neg  out  1  stride sign (= stride[10])
pfu_gsdb_strideh_6to0  out  7  |stride|[10:4] (stride in 16-byte units)
pfu_gsdb_vld  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; prev_va, stride_reg, cnt, priv_ff = 0; all outputs 0.
- en = pfu_dcache_pref_en | pfu_l2_pref_en.
- sample = ld_da_pfu_act_vld & ld_da_pfu_pf_inst_vld & en.
- diff = ld_da_pfu_va - prev_va, computed in 40 bits.
- in_range = diff is in [-1024, 1023] as signed.
- The zero-diff case is treated as a re-access of the same address. The sample is ignored completely: no state, counter or prev_va change.
- Every non-ignored sample updates prev_va <= ld_da_pfu_va.
- States: IDLE, TRAIN, CONFIRMED.
- IDLE: on sample, capture prev_va, set cnt = 0, move to TRAIN.
- TRAIN, in-range diff equal to stride_reg with cnt != 0: cnt++. Once cnt reaches CONF_THRESH, move to CONFIRMED and pulse create_vld in the next cycle.
- TRAIN, in-range diff not equal to stride_reg (or cnt == 0): stride_reg = diff[10:0], cnt = 1.
- TRAIN, out-of-range diff: cnt = 0, stride_reg = 0.
- CONFIRMED, matching diff: no change and no pulse. cnt saturates at CONF_THRESH.
- CONFIRMED, mismatching in-range diff: pop_req pulse; go to TRAIN with stride_reg = diff, cnt = 1.
- CONFIRMED, out-of-range diff: pop_req pulse; go to TRAIN with cnt = 0, stride_reg = 0.
- Latency: a triggering sample in cycle N gives its pulse in cycle N+1. create_vld and pop_req are never high together.
- Stride outputs are driven from stride_reg. While CONFIRMED, and in the cycle of create_vld, they are stable.
- priv_ff updates every cycle. If cp0_yy_priv_mode != priv_ff, or en falls: go to IDLE and clear state. pop_req pulses if the state was CONFIRMED.
- pfu_pop_all_vld: go to IDLE and clear state with no pop_req, because gpfb flushes itself.
- Priority, highest first: reset, pop_all, priv change / en drop, sample. A sample in the same cycle as a higher-priority event is dropped.
- pfu_gpfb_vld = 0 while CONFIRMED (gpfb dropped the stream, e.g. page error): return to TRAIN with cnt = CONF_THRESH-1 and stride_reg kept. The next matching sample re-creates the stream.
- Wrap-around: diff uses 40-bit modular arithmetic. VA 0xFF_FFFF_FFC0 followed by 0x00_0000_0000 gives diff = +64 (in range).

Test Plan:
- CONF_THRESH=3, samples VA 0x1000, 0x1040, 0x1080, 0x10C0 -> create_vld the cycle after the 4th sample; stride=0x040, neg=0, strideh=0x04; pop_req stays 0.
- Samples 0x2000, 0x1F80, 0x1F00, 0x1E80 -> create_vld; stride=0x780, neg=1, strideh=0x08.
- Confirmed +64 stream, then sample +0x80 -> pop_req for 1 cycle; state TRAIN, cnt=1. Two more +0x80 samples -> create_vld with stride=0x080.
- Training sequence with one diff of 0x800 inserted -> cnt clears and no create. Repeated identical VA -> ignored, counter unchanged.
- Confirmed stream with pfu_pop_all_vld and sample in the same cycle -> IDLE, no pop_req, gsdb_vld=0 next cycle. A priv mode change from 2'b00 to 2'b11 while CONFIRMED -> pop_req pulse, IDLE.
- cpurst_b asserted mid-TRAIN (cnt=2) -> all outputs 0 next cycle. After reset, 3 more +64 samples must not create; a 4th is required.
